// File: rtl/vc_mem_arbiter_if.sv
// Cache-side request/response signals and the byte-wide external memory bus
// shared by the I-cache fill path and the D-cache word path.
interface vc_mem_arbiter_if #(
  parameter int unsigned PA = 24
);
  logic          ic_req;
  logic [PA-1:0] ic_addr;
  logic [15:0]   ic_rdata;
  logic          ic_rvalid;
  logic          ic_done;

  logic          dc_req;
  logic          dc_we;
  logic [PA-1:0] dc_addr;
  logic [15:0]   dc_wdata;
  logic [15:0]   dc_rdata;
  logic          dc_rvalid;
  logic          dc_done;

  logic [7:0]    mem_out;
  logic          mem_oe;
  logic [7:0]    mem_in;
  logic          mem_cs;
  logic          mem_wr;
  logic          busy;

  // Arbiter side.
  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_in,
    output ic_rdata, ic_rvalid, ic_done, dc_rdata, dc_rvalid, dc_done,
    output mem_out, mem_oe, mem_cs, mem_wr, busy
  );

  // Requester / pin side.
  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_in,
    input  ic_rdata, ic_rvalid, ic_done, dc_rdata, dc_rvalid, dc_done,
    input  mem_out, mem_oe, mem_cs, mem_wr, busy
  );
endinterface

// File: rtl/vc_mem_arbiter.sv
// Arbitrates I-cache line fills and D-cache word accesses onto one byte-wide
// memory bus: three address bytes, read turnaround, then data bytes.
module vc_mem_arbiter #(
  parameter int unsigned PA         = 24,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned RD_LAT     = 2
) (
  input logic               clk,
  input logic               reset,
  vc_mem_arbiter_if.master  bus
);

  localparam int unsigned OFF_BITS  = $clog2(LINE_WORDS * 2);
  localparam logic [23:0] PA_MASK   = 24'((64'd1 << PA) - 64'd1);
  localparam logic [23:0] LINE_MASK = ~((24'd1 << OFF_BITS) - 24'd1);
  localparam logic [2:0]  LAST_WORD = 3'(LINE_WORDS - 1);
  localparam logic [2:0]  TURN_LAST = 3'(RD_LAT - 1);

  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] A2   = 4'd1;
  localparam logic [3:0] A1   = 4'd2;
  localparam logic [3:0] A0   = 4'd3;
  localparam logic [3:0] TURN = 4'd4;
  localparam logic [3:0] RL   = 4'd5;
  localparam logic [3:0] RH   = 4'd6;
  localparam logic [3:0] WL   = 4'd7;
  localparam logic [3:0] WH   = 4'd8;
  localparam logic [3:0] DONE = 4'd9;

  logic [3:0]  state_q, state_d;
  logic        gnt_q, last_q;
  logic [23:0] addr_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic [2:0]  turn_q;
  logic [2:0]  words_q;
  logic [7:0]  lo_q;
  logic [15:0] ic_rdata_q, dc_rdata_q;
  logic        ic_rvalid_q, dc_rvalid_q;

  logic        any_req;
  logic        pick_dc;
  logic [23:0] ic_addr_ext, dc_addr_ext;

  assign any_req     = bus.ic_req | bus.dc_req;
  // On a tie the requester that did not win last time is served.
  assign pick_dc     = bus.dc_req & (~bus.ic_req | (last_q == GNT_IC));
  assign ic_addr_ext = 24'(bus.ic_addr) & PA_MASK & LINE_MASK;
  assign dc_addr_ext = 24'(bus.dc_addr) & PA_MASK & 24'hFF_FFFE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = A2;
      A2:      state_d = A1;
      A1:      state_d = A0;
      A0:      state_d = we_q ? WL : TURN;
      TURN:    if (turn_q == 3'd0) state_d = RL;
      RL:      state_d = RH;
      RH:      state_d = (words_q == 3'd0) ? DONE : RL;
      WL:      state_d = WH;
      WH:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IC;
      last_q      <= GNT_IC;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      turn_q      <= '0;
      words_q     <= '0;
      lo_q        <= '0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        gnt_q   <= pick_dc;
        last_q  <= pick_dc;
        addr_q  <= pick_dc ? dc_addr_ext : ic_addr_ext;
        we_q    <= pick_dc & bus.dc_we;
        wdata_q <= bus.dc_wdata;
        words_q <= pick_dc ? 3'd0 : LAST_WORD;
      end
      if (state_q == A0) begin
        turn_q <= TURN_LAST;
      end else if (state_q == TURN) begin
        turn_q <= turn_q - 3'd1;
      end
      if (state_q == RL) lo_q <= bus.mem_in;
      if (state_q == RH && words_q != 3'd0) words_q <= words_q - 3'd1;
      // Read data is presented only in its valid cycle so idle outputs stay 0.
      ic_rvalid_q <= (state_q == RH) && (gnt_q == GNT_IC);
      dc_rvalid_q <= (state_q == RH) && (gnt_q == GNT_DC);
      ic_rdata_q  <= ((state_q == RH) && (gnt_q == GNT_IC)) ? {bus.mem_in, lo_q} : 16'h0;
      dc_rdata_q  <= ((state_q == RH) && (gnt_q == GNT_DC)) ? {bus.mem_in, lo_q} : 16'h0;
    end
  end

  logic [7:0] mem_out_c;
  always_comb begin
    mem_out_c = 8'h00;
    case (state_q)
      A2:      mem_out_c = addr_q[23:16];
      A1:      mem_out_c = addr_q[15:8];
      A0:      mem_out_c = addr_q[7:0];
      WL:      mem_out_c = wdata_q[7:0];
      WH:      mem_out_c = wdata_q[15:8];
      default: mem_out_c = 8'h00;
    endcase
  end

  logic cs_c, oe_c;
  assign cs_c = (state_q != IDLE) && (state_q != DONE);
  assign oe_c = (state_q == A2) || (state_q == A1) || (state_q == A0) ||
                (state_q == WL) || (state_q == WH);

  assign bus.mem_out   = mem_out_c;
  assign bus.mem_oe    = oe_c;
  assign bus.mem_cs    = cs_c;
  assign bus.mem_wr    = cs_c & we_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.ic_rvalid = ic_rvalid_q;
  assign bus.ic_done   = (state_q == DONE) && (gnt_q == GNT_IC);
  assign bus.dc_rdata  = dc_rdata_q;
  assign bus.dc_rvalid = dc_rvalid_q;
  assign bus.dc_done   = (state_q == DONE) && (gnt_q == GNT_DC);

endmodule

// File: tb/tb_vc_mem_arbiter.sv
// Directed bench for vc_mem_arbiter: read words go through a scoreboard queue,
// bus timing and handshakes are checked cycle by cycle.
module tb_vc_mem_arbiter;
  localparam int LW  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [16:0] sb[$];  // {is_dc, rdata}

  always #5 clk = ~clk;

  vc_mem_arbiter_if #(.PA(24)) bus ();

  vc_mem_arbiter #(.PA(24), .LINE_WORDS(LW), .RD_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input logic is_dc, input logic [15:0] data);
    logic [16:0] e;
    if (sb.size() == 0) begin
      check("rvalid_unexpected", {15'd0, is_dc, 1'b1}, {15'd0, is_dc, 1'b0});
    end else begin
      e = sb.pop_front();
      check("rd_requester", is_dc, e[16]);
      check("rdata", data, e[15:0]);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ic_rvalid) pop_check(1'b0, bus.ic_rdata);
    if (bus.dc_rvalid) pop_check(1'b1, bus.dc_rdata);
    if (!bus.mem_oe) check("out_zero_when_oe0", bus.mem_out, 0);
    if (!bus.mem_cs) check("wr_zero_when_cs0", bus.mem_wr, 0);
  end

  // Called in the IDLE cycle in which the request is visible; returns in DONE.
  task automatic do_read(input bit is_dc, input logic [23:0] exp_addr,
                         input logic [15:0] first, input bit disturb);
    int words;
    logic [7:0] lo, hi;
    words = is_dc ? 1 : LW;
    for (int i = 0; i < 3; i++) begin
      step();
      if (disturb && i == 1) begin
        bus.ic_addr = 24'hFFFFFF;
        bus.dc_we   = 1'b0;
        bus.dc_addr = 24'h223344;
        bus.dc_req  = 1'b1;
      end
      check("addr_byte", bus.mem_out, 32'(8'(exp_addr >> (16 - 8 * i))));
      check("addr_oe", bus.mem_oe, 1);
      check("addr_cs", bus.mem_cs, 1);
      check("rd_wr", bus.mem_wr, 0);
    end
    for (int i = 0; i < LAT; i++) begin
      step();
      check("turn_oe", bus.mem_oe, 0);
      check("turn_cs", bus.mem_cs, 1);
    end
    for (int w = 0; w < words; w++) begin
      lo = first[7:0] + 8'(2 * w);
      hi = first[15:8] + 8'(2 * w);
      step();
      bus.mem_in = lo;
      step();
      bus.mem_in = hi;
      sb.push_back({is_dc, hi, lo});
    end
    step();
    bus.mem_in = 8'h00;
    check("done", is_dc ? bus.dc_done : bus.ic_done, 1);
    check("last_rvalid_with_done", is_dc ? bus.dc_rvalid : bus.ic_rvalid, 1);
    check("other_done", is_dc ? bus.ic_done : bus.dc_done, 0);
    check("done_cs", bus.mem_cs, 0);
  endtask

  logic [7:0] wexp [5];

  initial begin
    reset        = 1'b1;
    bus.ic_req   = 1'b0;
    bus.ic_addr  = '0;
    bus.dc_req   = 1'b0;
    bus.dc_we    = 1'b0;
    bus.dc_addr  = '0;
    bus.dc_wdata = '0;
    bus.mem_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_cs", bus.mem_cs, 0);
    check("rst_oe", bus.mem_oe, 0);
    check("rst_wr", bus.mem_wr, 0);
    check("rst_out", bus.mem_out, 0);
    check("rst_dones", {bus.ic_done, bus.dc_done, bus.ic_rvalid, bus.dc_rvalid}, 0);
    check("rst_rdata", {bus.ic_rdata, bus.dc_rdata}, 0);
    reset = 1'b0;

    // Single I-cache fill.
    bus.ic_addr = 24'h123457;
    bus.ic_req  = 1'b1;
    do_read(1'b0, 24'h123450, 16'h0201, 1'b0);
    bus.ic_req = 1'b0;
    step();
    check("fill_busy_after", bus.busy, 0);

    // D-cache write.
    wexp = '{8'hAB, 8'hCD, 8'hE0, 8'hEF, 8'hBE};
    bus.dc_addr  = 24'hABCDE1;
    bus.dc_wdata = 16'hBEEF;
    bus.dc_we    = 1'b1;
    bus.dc_req   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("wr_byte", bus.mem_out, 32'(wexp[i]));
      check("wr_oe", bus.mem_oe, 1);
      check("wr_wr", bus.mem_wr, 1);
      check("wr_cs", bus.mem_cs, 1);
      check("wr_ic_quiet", {bus.ic_done, bus.ic_rvalid, bus.ic_rdata}, 0);
    end
    step();
    check("wr_done", bus.dc_done, 1);
    check("wr_no_rvalid", bus.dc_rvalid, 0);
    check("wr_done_cs", bus.mem_cs, 0);
    bus.dc_req = 1'b0;
    bus.dc_we  = 1'b0;
    step();
    check("wr_busy_after", bus.busy, 0);

    // D-cache read.
    bus.dc_addr = 24'h000103;
    bus.dc_req  = 1'b1;
    do_read(1'b1, 24'h000102, 16'h1234, 1'b0);
    bus.dc_req = 1'b0;
    step();

    // Both requesting from reset: D, I, D, I with one IDLE between.
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.ic_addr = 24'h112233;
    bus.dc_addr = 24'h445567;
    bus.ic_req  = 1'b1;
    bus.dc_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) do_read(1'b1, 24'h445566, 16'h2010 + 16'(k), 1'b0);
      else            do_read(1'b0, 24'h112230, 16'h3020 + 16'(k), 1'b0);
      if (k == 3) begin
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
      end
      step();
      check("gap_idle", bus.busy, 0);
    end

    // Reset during the third RL of a fill.
    bus.ic_addr = 24'h0A0B0C;
    bus.ic_req  = 1'b1;
    repeat (3 + LAT) step();
    for (int w = 0; w < 2; w++) begin
      step();
      bus.mem_in = 8'h50 + 8'(2 * w);
      step();
      bus.mem_in = 8'h51 + 8'(2 * w);
      sb.push_back({1'b0, 8'h51 + 8'(2 * w), 8'h50 + 8'(2 * w)});
    end
    step();
    bus.mem_in = 8'h99;
    reset      = 1'b1;
    bus.ic_req = 1'b0;
    step();
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_cs", bus.mem_cs, 0);
    check("mid_rst_done", bus.ic_done, 0);
    reset      = 1'b0;
    bus.mem_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_no_done", bus.ic_done, 0);
      check("mid_rst_idle", bus.busy, 0);
    end
    bus.ic_req = 1'b1;
    do_read(1'b0, 24'h0A0B08, 16'h4140, 1'b0);
    bus.ic_req = 1'b0;
    step();

    // Address change and D-cache request mid-burst.
    bus.ic_addr = 24'h102030;
    bus.ic_req  = 1'b1;
    do_read(1'b0, 24'h102030, 16'h6160, 1'b1);
    bus.ic_req = 1'b0;
    step();
    check("dc_wait_idle", bus.busy, 0);
    do_read(1'b1, 24'h223344, 16'h7170, 1'b0);
    bus.dc_req = 1'b0;
    step();
    check("end_idle", bus.busy, 0);
    step();
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
